// File: rtl/fir_result_capture.sv
// Sink for the fir_convolution output stream: drops `skip` fill beats, captures `length` samples,
// raises a sticky completion flag and offers a registered read port. FIR_RESULT_PEAK_EN adds peak |x| tracking.
module fir_result_capture #(
  parameter int length     = 60,
  parameter int data_width = 18,
  parameter int skip       = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic signed [3*data_width-1:0] data_in,
  input  logic                           read_enable,
  input  logic [$clog2(length)-1:0]      read_addr,
  output logic signed [3*data_width-1:0] data_out,
  output logic                           read_valid,
  output logic [$clog2(length+1)-1:0]    sample_count,
  output logic                           result_set_flag
`ifdef FIR_RESULT_PEAK_EN
  ,
  output logic [3*data_width-1:0]        peak_abs,
  output logic [$clog2(length)-1:0]      peak_addr
`endif
);

  localparam int sampleWidth = 3 * data_width;
  localparam int addrWidth   = $clog2(length);
  localparam int countWidth  = $clog2(length + 1);
  localparam logic [7:0] skipTarget = 8'(skip);
  localparam logic [countWidth-1:0] lastCount = countWidth'(length - 1);

  typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DONE} captureState;

  captureState stateReg, stateNext;
  logic [7:0] skipCountReg, skipCountNext;
  logic [countWidth-1:0] countReg, countNext;
  logic flagReg, flagNext;
  logic writeEn;
  logic [addrWidth-1:0] writeAddr;
  logic addrInRange;
  logic [sampleWidth-1:0] mem [length];

  // The running sample count doubles as the next write address.
  assign writeAddr       = countReg[addrWidth-1:0];
  assign sample_count    = countReg;
  assign result_set_flag = flagReg;

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg     <= IDLE;
      skipCountReg <= '0;
      countReg     <= '0;
      flagReg      <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      skipCountReg <= skipCountNext;
      countReg     <= countNext;
      flagReg      <= flagNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    skipCountNext = skipCountReg;
    countNext     = countReg;
    flagNext      = flagReg;
    writeEn       = 1'b0;
    case (stateReg)
      IDLE: begin
        if (enable) begin
          if (skip == 0) begin
            writeEn   = 1'b1;
            countNext = countWidth'(1);
            stateNext = CAPTURE;
          end else begin
            skipCountNext = 8'd1;
            stateNext     = (skip == 1) ? CAPTURE : SKIP;
          end
        end
      end
      SKIP: begin
        if (enable) begin
          skipCountNext = skipCountReg + 8'd1;
          if (skipCountReg + 8'd1 == skipTarget) begin
            stateNext = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (enable) begin
          writeEn   = 1'b1;
          countNext = countReg + countWidth'(1);
          if (countReg == lastCount) begin
            stateNext = DONE;
            flagNext  = 1'b1;
          end
        end
      end
      DONE: begin
        stateNext = DONE;
      end
    endcase
  end

  // Reset beats are never written; buffer contents otherwise survive reset.
  always_ff @(posedge clock) begin
    if (writeEn && !reset) begin
      mem[writeAddr] <= data_in;
    end
  end

  // Only a non-power-of-two depth leaves address codes outside the buffer.
  generate
    if ((1 << addrWidth) > length) begin : gRangeCheck
      assign addrInRange = (read_addr < addrWidth'(length));
    end else begin : gFullRange
      assign addrInRange = 1'b1;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      data_out   <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= read_enable;
      if (read_enable) begin
        data_out <= addrInRange ? mem[read_addr] : '0;
      end
    end
  end

`ifdef FIR_RESULT_PEAK_EN
  localparam logic [sampleWidth-1:0] mostNegative = {1'b1, {(sampleWidth-1){1'b0}}};
  localparam logic [sampleWidth-1:0] mostPositive = {1'b0, {(sampleWidth-1){1'b1}}};

  logic [sampleWidth-1:0] rawSample, sampleAbs, peakAbsReg;
  logic [addrWidth-1:0] peakAddrReg;

  assign rawSample = data_in;
  assign peak_abs  = peakAbsReg;
  assign peak_addr = peakAddrReg;

  // |most negative| has no positive twin, so it saturates.
  always_comb begin
    sampleAbs = rawSample;
    if (rawSample == mostNegative) begin
      sampleAbs = mostPositive;
    end else if (rawSample[sampleWidth-1]) begin
      sampleAbs = -rawSample;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      peakAbsReg  <= '0;
      peakAddrReg <= '0;
    end else if (writeEn && (sampleAbs > peakAbsReg)) begin
      peakAbsReg  <= sampleAbs;
      peakAddrReg <= writeAddr;
    end
  end
`endif

endmodule

// File: tb/tb_fir_result_capture.sv
// Scoreboard bench for fir_result_capture: three instances with different length/skip share one stimulus
// stream; a beat-count reference model predicts reads, counts, flags and (if FIR_RESULT_PEAK_EN) peaks.
module tb_fir_result_capture;

  localparam int DW = 18;
  localparam int SW = 3 * DW;
  localparam int N  = 3;
  localparam int LEN[N] = '{4, 4, 5};
  localparam int SKP[N] = '{0, 2, 1};
  localparam int AWD[N] = '{2, 2, 3};

  typedef struct {
    bit          check;
    logic [SW-1:0] value;
    int          addr;
  } readExp;

  logic clock = 1'b0;
  logic reset, enable, readEnable;
  logic [SW-1:0] dataIn;
  logic [2:0] readAddr;
  logic [SW-1:0] dout [N];
  logic readValid [N];
  logic [2:0] cnt [N];
  logic flag [N];
`ifdef FIR_RESULT_PEAK_EN
  logic [SW-1:0] peak [N];
  logic [1:0] peakAddrA, peakAddrB;
  logic [2:0] peakAddrC;
`endif

  int tests = 0;
  int failed = 0;
  readExp sbq [N][$];

  int beats [N];
  logic [SW-1:0] memModel [N][8];
  bit known [N][8];
  logic [SW-1:0] peakModel [N];
  int peakAddrModel [N];

  always #5 clock = ~clock;

  fir_result_capture #(.length(4), .data_width(DW), .skip(0)) dutA (
    .clock(clock), .reset(reset), .enable(enable), .data_in(dataIn),
    .read_enable(readEnable), .read_addr(readAddr[1:0]),
    .data_out(dout[0]), .read_valid(readValid[0]),
    .sample_count(cnt[0]), .result_set_flag(flag[0])
`ifdef FIR_RESULT_PEAK_EN
    , .peak_abs(peak[0]), .peak_addr(peakAddrA)
`endif
  );

  fir_result_capture #(.length(4), .data_width(DW), .skip(2)) dutB (
    .clock(clock), .reset(reset), .enable(enable), .data_in(dataIn),
    .read_enable(readEnable), .read_addr(readAddr[1:0]),
    .data_out(dout[1]), .read_valid(readValid[1]),
    .sample_count(cnt[1]), .result_set_flag(flag[1])
`ifdef FIR_RESULT_PEAK_EN
    , .peak_abs(peak[1]), .peak_addr(peakAddrB)
`endif
  );

  fir_result_capture #(.length(5), .data_width(DW), .skip(1)) dutC (
    .clock(clock), .reset(reset), .enable(enable), .data_in(dataIn),
    .read_enable(readEnable), .read_addr(readAddr),
    .data_out(dout[2]), .read_valid(readValid[2]),
    .sample_count(cnt[2]), .result_set_flag(flag[2])
`ifdef FIR_RESULT_PEAK_EN
    , .peak_abs(peak[2]), .peak_addr(peakAddrC)
`endif
  );

  function automatic logic [SW-1:0] sx(input int v);
    return SW'(v);
  endfunction

  function automatic logic [SW-1:0] absSat(input logic [SW-1:0] x);
    logic [SW-1:0] minVal;
    minVal = {1'b1, {(SW-1){1'b0}}};
    if (x == minVal) return minVal - 1;
    if (x[SW-1]) return -x;
    return x;
  endfunction

  task automatic checkVal(input string name, input int k, input logic [63:0] actual, input logic [63:0] required);
    tests++;
    if (actual !== required) begin
      failed++;
      $display("FAIL %s dut%0d: got 0x%0h, required 0x%0h", name, k, actual, required);
    end
  endtask

  // Model: beat index b lands in slot b-skip while that slot is below length; everything else is dropped.
  task automatic modelReset(input int k);
    beats[k] = 0;
    peakModel[k] = '0;
    peakAddrModel[k] = 0;
  endtask

  task automatic modelBeat(input int k, input logic [SW-1:0] x);
    int slot;
    slot = beats[k] - SKP[k];
    if (slot >= 0 && slot < LEN[k]) begin
      memModel[k][slot] = x;
      known[k][slot] = 1'b1;
      if (absSat(x) > peakModel[k]) begin
        peakModel[k] = absSat(x);
        peakAddrModel[k] = slot;
      end
    end
    beats[k]++;
  endtask

  function automatic readExp expectRead(input int k, input logic [2:0] ra);
    readExp e;
    int a;
    a = int'(ra) & ((1 << AWD[k]) - 1);
    e.addr = a;
    if (a >= LEN[k]) begin
      e.check = 1'b1;
      e.value = '0;
    end else begin
      e.check = known[k][a];
      e.value = memModel[k][a];
    end
    return e;
  endfunction

`ifdef FIR_RESULT_PEAK_EN
  function automatic int peakAddrOf(input int k);
    if (k == 0) return int'(peakAddrA);
    if (k == 1) return int'(peakAddrB);
    return int'(peakAddrC);
  endfunction
`endif

  task automatic checkStatus();
    for (int k = 0; k < N; k++) begin
      int expCount;
      expCount = beats[k] - SKP[k];
      if (expCount < 0) expCount = 0;
      if (expCount > LEN[k]) expCount = LEN[k];
      checkVal("sample_count", k, 64'(cnt[k]), 64'(expCount));
      checkVal("result_set_flag", k, 64'(flag[k]), 64'(beats[k] >= SKP[k] + LEN[k]));
`ifdef FIR_RESULT_PEAK_EN
      checkVal("peak_abs", k, 64'(peak[k]), 64'(peakModel[k]));
      checkVal("peak_addr", k, 64'(peakAddrOf(k)), 64'(peakAddrModel[k]));
`endif
    end
  endtask

  // One clock of stimulus; reads are predicted before this edge's write (read-before-write).
  task automatic step(input bit rst, input bit en, input logic [SW-1:0] din, input bit ren, input logic [2:0] ra);
    @(negedge clock);
    reset = rst;
    enable = en;
    dataIn = din;
    readEnable = ren;
    readAddr = ra;
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        modelReset(k);
      end else begin
        if (ren) sbq[k].push_back(expectRead(k, ra));
        if (en) modelBeat(k, din);
      end
    end
    @(posedge clock);
    #1;
    checkStatus();
  endtask

  task automatic beat(input logic [SW-1:0] x);
    step(1'b0, 1'b1, x, 1'b0, 3'd0);
  endtask

  task automatic gap();
    step(1'b0, 1'b0, '0, 1'b0, 3'd0);
  endtask

  task automatic rd(input int a);
    step(1'b0, 1'b0, '0, 1'b1, 3'(a));
  endtask

  task automatic rst();
    step(1'b1, 1'b0, '0, 1'b0, 3'd0);
  endtask

  function automatic logic [SW-1:0] randSample();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0, 1, 2: return sx(int'($urandom_range(0, 2000)) - 1000);
      3, 4:    return r[SW-1:0];
      5:       return {1'b1, {(SW-1){1'b0}}};
      default: return r[SW-1:0] >> $urandom_range(0, 50);
    endcase
  endfunction

  // Monitor: every read_valid pops one scoreboard entry for that instance.
  initial begin
    readExp e;
    forever begin
      @(negedge clock);
      for (int k = 0; k < N; k++) begin
        if (readValid[k] === 1'b1) begin
          if (sbq[k].size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_read_valid dut%0d: got read_valid=1, required 0", k);
          end else begin
            e = sbq[k].pop_front();
            $display("[TB] dut%0d read addr %0d data 0x%0h%s", k, e.addr, dout[k], e.check ? "" : " (stale, unchecked)");
            if (e.check) checkVal("read_data", k, 64'(dout[k]), 64'(e.value));
          end
        end
      end
    end
  end

  initial begin
    logic [SW-1:0] minSample;
    bit rr, ren;
    minSample = {1'b1, {(SW-1){1'b0}}};
    reset = 1'b1;
    enable = 1'b0;
    dataIn = '0;
    readEnable = 1'b0;
    readAddr = '0;
    for (int k = 0; k < N; k++) begin
      modelReset(k);
      for (int a = 0; a < 8; a++) known[k][a] = 1'b0;
    end

    rst();
    rst();
    for (int k = 0; k < N; k++) begin
      checkVal("reset_data_out", k, 64'(dout[k]), 64'd0);
      checkVal("reset_read_valid", k, 64'(readValid[k]), 64'd0);
    end

    // Back-to-back capture and full readback, including out-of-range addresses.
    rst();
    beat(sx(10)); beat(sx(-20)); beat(sx(30)); beat(sx(-40));
    for (int a = 0; a < 8; a++) rd(a);
    gap();

    // Fill-latency skip, then beats after completion must be ignored.
    rst();
    for (int v = 1; v <= 6; v++) beat(sx(v));
    beat(sx(99)); beat(sx(99));
    for (int a = 0; a < 4; a++) rd(a);
    gap();

    // Gapped enable.
    rst();
    beat(sx(7)); gap(); beat(sx(8)); gap(); beat(sx(9)); gap(); beat(sx(10));
    for (int a = 0; a < 4; a++) rd(a);
    gap();

    // Same-cycle write and read of address 1 returns the old word.
    rst();
    beat(sx(1));
    step(1'b0, 1'b1, sx(55), 1'b1, 3'd1);
    rd(1);
    gap();

    // Reset concurrent with a beat wins; a fresh run then completes.
    rst();
    beat(sx(1)); beat(sx(2));
    step(1'b1, 1'b1, sx(77), 1'b0, 3'd0);
    for (int v = 1; v <= 4; v++) beat(sx(v));
    for (int a = 0; a < 5; a++) rd(a);
    gap();

    // Peak tracking: ties keep the earliest address, most-negative saturates.
    rst();
    beat(sx(500)); beat(sx(-7)); beat(sx(12)); beat(sx(-12)); beat(sx(3));
`ifdef FIR_RESULT_PEAK_EN
    checkVal("peak_abs_directed", 2, 64'(peak[2]), 64'd12);
    checkVal("peak_addr_directed", 2, 64'(peakAddrC), 64'd1);
`endif
    beat(minSample);
`ifdef FIR_RESULT_PEAK_EN
    checkVal("peak_abs_saturated", 2, 64'(peak[2]), (64'd1 << 53) - 64'd1);
`endif
    for (int a = 0; a < 5; a++) rd(a);
    gap();

    // Randomised traffic with occasional resets.
    rst();
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 49) == 0);
      ren = !rr && ($urandom_range(0, 1) == 1);
      step(rr, $urandom_range(0, 9) < 7, randSample(), ren, 3'($urandom_range(0, 7)));
    end
    gap();
    gap();

    for (int k = 0; k < N; k++) begin
      checkVal("scoreboard_drained", k, 64'(sbq[k].size()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
